// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue stage: operation codes, alu_op classes and the buffered item.
// Optional field/helper under ALU_ISSUE_ILLEGAL_CHECK_EN.
package alu_issue_pkg;

  localparam int DATA_W   = 32;
  localparam int OPCODE_W = 4;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_XOR   = 4'b0011,
    OP_SLL   = 4'b0100,
    OP_SRL   = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_SRA   = 4'b0111,
    OP_EQ    = 4'b1000,
    OP_NE    = 4'b1001,
    OP_JAL   = 4'b1010,
    OP_NEVER = 4'b1011,
    OP_LT    = 4'b1100,
    OP_GE    = 4'b1101,
    OP_LTU   = 4'b1110,
    OP_GEU   = 4'b1111
  } alu_operation_e;

  typedef enum logic [1:0] {
    CLS_MEM    = 2'b00,
    CLS_BRANCH = 2'b01,
    CLS_RTYPE  = 2'b10,
    CLS_ITYPE  = 2'b11
  } alu_class_e;

  typedef struct packed {
    logic [OPCODE_W-1:0] operation;
    logic [DATA_W-1:0]   src_a;
    logic [DATA_W-1:0]   src_b;
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
    logic                illegal;
`endif
  } issue_item_t;

`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
  function automatic logic funct7_legal(input logic [6:0] funct7);
    return (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
  endfunction
`endif

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct3/funct7 -> 4-bit Operation translation.
// Adds illegal_o when ALU_ISSUE_ILLEGAL_CHECK_EN is defined.
module alu_op_decode
  import alu_issue_pkg::*;
(
  input  logic [1:0]          alu_op_i,
  input  logic                is_jal_i,
  input  logic [2:0]          funct3_i,
  input  logic [6:0]          funct7_i,
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
  output logic                illegal_o,
`endif
  output logic [OPCODE_W-1:0] operation_o
);

  alu_operation_e op;

  always_comb begin
    // NOTE: defaults first, so no branch leaves op unassigned and no latch is inferred.
    op = OP_ADD;
    if (is_jal_i) begin
      op = OP_JAL;
    end else begin
      unique case (alu_class_e'(alu_op_i))
        CLS_MEM: op = OP_ADD;
        CLS_BRANCH: begin
          unique case (funct3_i)
            3'b000:  op = OP_EQ;
            3'b001:  op = OP_NE;
            3'b100:  op = OP_LT;
            3'b101:  op = OP_GE;
            3'b110:  op = OP_LTU;
            3'b111:  op = OP_GEU;
            default: op = OP_NEVER;
          endcase
        end
        CLS_RTYPE, CLS_ITYPE: begin
          unique case (funct3_i)
            // funct7 is immediate bits for I-type, so ADDI never becomes SUB.
            3'b000: op = (alu_op_i == CLS_RTYPE && funct7_i[5]) ? OP_SUB : OP_ADD;
            3'b001: op = OP_SLL;
            3'b010: op = OP_LT;
            3'b011: op = OP_LTU;
            3'b100: op = OP_XOR;
            3'b101: op = funct7_i[5] ? OP_SRA : OP_SRL;
            3'b110: op = OP_OR;
            3'b111: op = OP_AND;
          endcase
        end
      endcase
    end
  end

  assign operation_o = op;

`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
  always_comb begin
    illegal_o = 1'b0;
    if (!is_jal_i) begin
      unique case (alu_class_e'(alu_op_i))
        CLS_BRANCH: illegal_o = (funct3_i[2:1] == 2'b01);
        CLS_RTYPE:  illegal_o = !funct7_legal(funct7_i) ||
                                (funct7_i[5] && funct3_i != 3'b000 && funct3_i != 3'b101);
        CLS_ITYPE:  illegal_o = (funct3_i == 3'b001 && funct7_i != 7'b0000000) ||
                                (funct3_i == 3'b101 && !funct7_legal(funct7_i));
        default:    illegal_o = 1'b0;
      endcase
    end
  end
`else
  logic unused_funct7;
  assign unused_funct7 = ^{funct7_i[6], funct7_i[4:0]};
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode + operand select into an output register backed by one skid entry.
// Optional illegal output under ALU_ISSUE_ILLEGAL_CHECK_EN.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  // Buffered items use the package widths; keep these at their defaults.
  parameter int DATA_WIDTH    = DATA_W,
  parameter int OPCODE_LENGTH = OPCODE_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               alu_op,
  input  logic                     is_jal,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic                     alu_src,
  input  logic [DATA_WIDTH-1:0]    rs1_data,
  input  logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic [DATA_WIDTH-1:0]    imm,
  output logic                     out_valid,
  input  logic                     out_ready,
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
  output logic                     illegal,
`endif
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB
);

  issue_item_t         in_item, out_q, out_d, skid_q;
  logic                out_valid_q, out_valid_d;
  logic                skid_valid_q, skid_valid_d;
  logic                skid_load, in_fire, out_free;
  logic [OPCODE_W-1:0] dec_op;

  alu_op_decode u_decode (
    .alu_op_i    (alu_op),
    .is_jal_i    (is_jal),
    .funct3_i    (funct3),
    .funct7_i    (funct7),
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
    .illegal_o   (in_item.illegal),
`endif
    .operation_o (dec_op)
  );

  assign in_item.operation = dec_op;
  assign in_item.src_a     = rs1_data;
  assign in_item.src_b     = alu_src ? imm : rs2_data;

  // in_ready comes straight from a flop, so EX stalls never reach ID combinationally.
  assign in_ready = ~skid_valid_q;
  assign in_fire  = in_valid & in_ready;
  assign out_free = ~out_valid_q | out_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    skid_load    = 1'b0;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        // Skid is full only when in_ready was low, so no new item competes here.
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) out_d = in_item;
      end
    end else if (in_fire) begin
      skid_load    = 1'b1;
      skid_valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // NOTE: the skid payload is qualified by skid_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (skid_load) skid_q <= in_item;
  end

  assign out_valid = out_valid_q;
  assign Operation = out_q.operation;
  assign SrcA      = out_q.src_a;
  assign SrcB      = out_q.src_b;
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
  assign illegal   = out_q.illegal;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected items queued on accept, compared while at the output.
// Also checks the illegal flag when ALU_ISSUE_ILLEGAL_CHECK_EN is defined.
module tb_alu_issue_stage;

  typedef struct {
    logic [1:0]  alu_op;
    logic        is_jal;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        alu_src;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [3:0]  exp_op;
    logic        exp_ill;
  } stim_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, is_jal, alu_src, out_valid, out_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1_data, rs2_data, imm, SrcA, SrcB;
  logic [3:0]  Operation;
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
  logic        illegal;
`endif

  int    n_checks = 0;
  int    n_errors = 0;
  exp_t  exp_q[$];
  stim_t tbl[$];
  stim_t idle;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .is_jal    (is_jal),
    .funct3    (funct3),
    .funct7    (funct7),
    .alu_src   (alu_src),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
    .illegal   (illegal),
`endif
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic stim_t mk(input logic [1:0] op, input logic j, input logic [2:0] f3,
                               input logic [6:0] f7, input logic src, input logic [31:0] r1,
                               input logic [31:0] r2, input logic [31:0] im,
                               input logic [3:0] eop, input logic eill);
    stim_t s;
    s.alu_op = op;  s.is_jal = j;   s.funct3 = f3;  s.funct7 = f7;   s.alu_src = src;
    s.rs1    = r1;  s.rs2    = r2;  s.imm    = im;  s.exp_op = eop;  s.exp_ill = eill;
    return s;
  endfunction

  function automatic exp_t expect_of(input stim_t s);
    exp_t e;
    e.op  = s.exp_op;
    e.a   = s.rs1;
    e.b   = s.alu_src ? s.imm : s.rs2;
    e.ill = s.exp_ill;
    return e;
  endfunction

  task automatic check_state();
    check("in_ready", in_ready, exp_q.size() < 2);
    check("out_valid", out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check("Operation", Operation, exp_q[0].op);
      check("SrcA", SrcA, exp_q[0].a);
      check("SrcB", SrcB, exp_q[0].b);
`ifdef ALU_ISSUE_ILLEGAL_CHECK_EN
      check("illegal", illegal, exp_q[0].ill);
`endif
    end
  endtask

  // One clock: drive at negedge, update the scoreboard at posedge, compare at the next negedge.
  task automatic cyc(input stim_t s, input logic vld, input logic ordy, input logic flsh);
    int sz;
    in_valid = vld;       alu_op   = s.alu_op;  is_jal   = s.is_jal;  funct3 = s.funct3;
    funct7   = s.funct7;  alu_src  = s.alu_src; rs1_data = s.rs1;     rs2_data = s.rs2;
    imm      = s.imm;     out_ready = ordy;     flush    = flsh;
    @(posedge clk);
    sz = exp_q.size();
    if (flsh) begin
      exp_q.delete();
    end else begin
      if (sz > 0 && ordy) void'(exp_q.pop_front());
      if (vld && sz < 2) exp_q.push_back(expect_of(s));
    end
    @(negedge clk);
    check_state();
  endtask

  initial begin
    stim_t a, b, c;
    idle = mk(2'b00, 1'b0, 3'b000, 7'h00, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; alu_op = 2'b00;
    is_jal = 1'b0; funct3 = 3'b000; funct7 = 7'h00; alu_src = 1'b0;
    rs1_data = '0; rs2_data = '0; imm = '0;
    #1 reset = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst out_valid", out_valid, 1'b0);
    check("rst in_ready", in_ready, 1'b1);
    check("rst Operation", Operation, 4'b0000);
    check("rst SrcA", SrcA, 32'h0);
    check("rst SrcB", SrcB, 32'h0);
    reset = 1'b0;

    // R-type SUB, then I-type funct3=000 with funct7[5]=1 that must stay ADD.
    cyc(mk(2'b10, 1'b0, 3'b000, 7'h20, 1'b0, 32'd7, 32'd3, 32'd99, 4'b0110, 1'b0), 1'b1, 1'b1, 1'b0);
    cyc(idle, 1'b0, 1'b1, 1'b0);
    cyc(mk(2'b11, 1'b0, 3'b000, 7'h20, 1'b1, 32'd5, 32'd1, 32'hFFFF_FFFC, 4'b0010, 1'b0),
        1'b1, 1'b1, 1'b0);
    cyc(idle, 1'b0, 1'b1, 1'b0);

    // Decode table: alu_op, jal, funct3, funct7, alu_src, expected op, expected illegal.
    tbl.push_back(mk(2'b10, 1'b0, 3'b001, 7'h00, 1'b0, $urandom(), $urandom(), $urandom(), 4'b0100, 1'b0));
    tbl.push_back(mk(2'b10, 1'b0, 3'b010, 7'h00, 1'b1, $urandom(), $urandom(), $urandom(), 4'b1100, 1'b0));
    tbl.push_back(mk(2'b10, 1'b0, 3'b011, 7'h00, 1'b0, $urandom(), $urandom(), $urandom(), 4'b1110, 1'b0));
    tbl.push_back(mk(2'b10, 1'b0, 3'b100, 7'h00, 1'b0, $urandom(), $urandom(), $urandom(), 4'b0011, 1'b0));
    tbl.push_back(mk(2'b10, 1'b0, 3'b101, 7'h00, 1'b0, $urandom(), $urandom(), $urandom(), 4'b0101, 1'b0));
    tbl.push_back(mk(2'b10, 1'b0, 3'b101, 7'h20, 1'b0, $urandom(), $urandom(), $urandom(), 4'b0111, 1'b0));
    tbl.push_back(mk(2'b10, 1'b0, 3'b110, 7'h00, 1'b1, $urandom(), $urandom(), $urandom(), 4'b0001, 1'b0));
    tbl.push_back(mk(2'b10, 1'b0, 3'b111, 7'h00, 1'b0, $urandom(), $urandom(), $urandom(), 4'b0000, 1'b0));
    tbl.push_back(mk(2'b10, 1'b0, 3'b000, 7'h00, 1'b0, $urandom(), $urandom(), $urandom(), 4'b0010, 1'b0));
    tbl.push_back(mk(2'b10, 1'b0, 3'b000, 7'h01, 1'b0, $urandom(), $urandom(), $urandom(), 4'b0010, 1'b1));
    tbl.push_back(mk(2'b10, 1'b0, 3'b100, 7'h20, 1'b0, $urandom(), $urandom(), $urandom(), 4'b0011, 1'b1));
    tbl.push_back(mk(2'b11, 1'b0, 3'b001, 7'h00, 1'b1, $urandom(), $urandom(), $urandom(), 4'b0100, 1'b0));
    tbl.push_back(mk(2'b11, 1'b0, 3'b001, 7'h10, 1'b1, $urandom(), $urandom(), $urandom(), 4'b0100, 1'b1));
    tbl.push_back(mk(2'b11, 1'b0, 3'b101, 7'h00, 1'b1, $urandom(), $urandom(), $urandom(), 4'b0101, 1'b0));
    tbl.push_back(mk(2'b11, 1'b0, 3'b101, 7'h21, 1'b1, $urandom(), $urandom(), $urandom(), 4'b0111, 1'b1));
    tbl.push_back(mk(2'b11, 1'b0, 3'b010, 7'h7F, 1'b1, $urandom(), $urandom(), $urandom(), 4'b1100, 1'b0));
    tbl.push_back(mk(2'b11, 1'b0, 3'b110, 7'h55, 1'b1, $urandom(), $urandom(), $urandom(), 4'b0001, 1'b0));
    tbl.push_back(mk(2'b01, 1'b0, 3'b000, 7'h00, 1'b0, $urandom(), $urandom(), $urandom(), 4'b1000, 1'b0));
    tbl.push_back(mk(2'b01, 1'b0, 3'b001, 7'h00, 1'b0, $urandom(), $urandom(), $urandom(), 4'b1001, 1'b0));
    tbl.push_back(mk(2'b01, 1'b0, 3'b010, 7'h00, 1'b0, $urandom(), $urandom(), $urandom(), 4'b1011, 1'b1));
    tbl.push_back(mk(2'b01, 1'b0, 3'b011, 7'h00, 1'b0, $urandom(), $urandom(), $urandom(), 4'b1011, 1'b1));
    tbl.push_back(mk(2'b01, 1'b0, 3'b100, 7'h00, 1'b0, $urandom(), $urandom(), $urandom(), 4'b1100, 1'b0));
    tbl.push_back(mk(2'b01, 1'b0, 3'b101, 7'h00, 1'b0, $urandom(), $urandom(), $urandom(), 4'b1101, 1'b0));
    tbl.push_back(mk(2'b01, 1'b0, 3'b110, 7'h00, 1'b0, $urandom(), $urandom(), $urandom(), 4'b1110, 1'b0));
    tbl.push_back(mk(2'b01, 1'b0, 3'b111, 7'h00, 1'b0, $urandom(), $urandom(), $urandom(), 4'b1111, 1'b0));
    tbl.push_back(mk(2'b00, 1'b0, 3'b010, 7'h3F, 1'b1, $urandom(), $urandom(), $urandom(), 4'b0010, 1'b0));
    tbl.push_back(mk(2'b10, 1'b1, 3'b000, 7'h20, 1'b1, $urandom(), $urandom(), $urandom(), 4'b1010, 1'b0));
    tbl.push_back(mk(2'b01, 1'b1, 3'b010, 7'h00, 1'b1, $urandom(), $urandom(), $urandom(), 4'b1010, 1'b0));

    // Back-to-back sweep at full throughput.
    foreach (tbl[i]) cyc(tbl[i], 1'b1, 1'b1, 1'b0);
    cyc(idle, 1'b0, 1'b1, 1'b0);
    cyc(idle, 1'b0, 1'b1, 1'b0);

    // Backpressure: A and B held, C waits, then A, B, C drain in order.
    a = mk(2'b01, 1'b0, 3'b000, 7'h00, 1'b0, 32'hA1, 32'hA2, 32'hA3, 4'b1000, 1'b0);
    b = mk(2'b11, 1'b0, 3'b101, 7'h20, 1'b1, 32'hB1, 32'hB2, 32'hB3, 4'b0111, 1'b0);
    c = mk(2'b00, 1'b1, 3'b000, 7'h00, 1'b1, 32'hC1, 32'hC2, 32'hC3, 4'b1010, 1'b0);
    cyc(a, 1'b1, 1'b0, 1'b0);
    cyc(b, 1'b1, 1'b0, 1'b0);
    cyc(c, 1'b1, 1'b0, 1'b0);
    cyc(c, 1'b1, 1'b1, 1'b0);
    cyc(c, 1'b1, 1'b1, 1'b0);
    cyc(idle, 1'b0, 1'b1, 1'b0);
    cyc(idle, 1'b0, 1'b1, 1'b0);

    // Full buffer, flush together with an offered input: everything is dropped.
    cyc(tbl[0], 1'b1, 1'b0, 1'b0);
    cyc(tbl[1], 1'b1, 1'b0, 1'b0);
    cyc(tbl[2], 1'b1, 1'b1, 1'b1);
    cyc(idle, 1'b0, 1'b1, 1'b0);
    cyc(idle, 1'b0, 1'b1, 1'b0);

    // Flush with a simultaneous drain of a single item.
    cyc(tbl[3], 1'b1, 1'b1, 1'b0);
    cyc(idle, 1'b0, 1'b1, 1'b1);
    cyc(tbl[4], 1'b1, 1'b1, 1'b0);
    cyc(idle, 1'b0, 1'b1, 1'b0);

    // Random valid/ready traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      cyc(tbl[$urandom_range(0, tbl.size() - 1)], 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    end
    for (int i = 0; i < 3; i++) cyc(idle, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset between edges while an item is on the output.
    cyc(tbl[5], 1'b1, 1'b0, 1'b0);
    cyc(tbl[6], 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async out_valid", out_valid, 1'b0);
    check("async in_ready", in_ready, 1'b1);
    check("async Operation", Operation, 4'b0000);
    check("async SrcA", SrcA, 32'h0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    check_state();
    cyc(idle, 1'b0, 1'b1, 1'b0);
    cyc(tbl[7], 1'b1, 1'b1, 1'b0);
    cyc(tbl[8], 1'b1, 1'b0, 1'b0);
    cyc(idle, 1'b0, 1'b1, 1'b0);
    cyc(idle, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
